// File: rtl/scan_pq.sv
// scan_pq - priority-queue device for the pq_if dev side.
//
// The entries live in an unsorted register array. An enqueue appends in one
// cycle. After every accepted operation a linear scan walks the valid
// entries, one per cycle, and presents the minimum-key entry on kvo. busy
// stays high for the whole scan, and requests that arrive during a scan are
// dropped.
//
// Parameters: DEPTH (entries, >= 2), KW (key width), VW (value width).
// An entry is {key, value}; a smaller key means higher priority.
//
// Ports:
//   clk   in       clock, rising edge
//   rst   in       synchronous active-high reset
//   enq   in       enqueue request (sampled in IDLE only)
//   deq   in       dequeue-minimum request (sampled in IDLE only)
//   kvi   in  [KW+VW] entry to enqueue
//   kvo   out [KW+VW] current minimum entry (registered, valid when !busy)
//   full  out      count == DEPTH
//   empty out      count == 0
//   busy  out      scan in progress
//   err   out      sticky dropped-request flag (only with PQ_ERR_EN defined)
//
// Optional feature macro: PQ_ERR_EN adds the err output.
module scan_pq #(
  parameter int DEPTH = 16,
  parameter int KW    = 8,
  parameter int VW    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enq,
  input  logic             deq,
  input  logic [KW+VW-1:0] kvi,
  output logic [KW+VW-1:0] kvo,
  output logic             full,
  output logic             empty,
  output logic             busy
`ifdef PQ_ERR_EN
  ,
  output logic             err
`endif
);

  localparam int DW = KW + VW;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic {IDLE, SCAN} state_e;

  state_e        state_q, state_d;
  logic [DW-1:0] arr_q [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] idx_q, idx_d;
  logic [IW-1:0] best_q, best_d;
  logic [IW-1:0] min_idx_q, min_idx_d;
  logic [DW-1:0] kvo_q, kvo_d;

  logic          wr_en;
  logic [IW-1:0] wr_idx;
  logic [DW-1:0] wr_data;

  logic [KW-1:0] cur_key, best_key;
  logic          take;
  logic [IW-1:0] sel;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign busy  = (state_q == SCAN);
  assign kvo   = kvo_q;

  // Scan compare: the first index seeds the running best; afterwards a
  // strict < keeps the lower index on equal keys.
  assign cur_key  = arr_q[idx_q[IW-1:0]][DW-1:VW];
  assign best_key = arr_q[best_q][DW-1:VW];
  assign take     = (idx_q == '0) || (cur_key < best_key);
  assign sel      = take ? idx_q[IW-1:0] : best_q;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    idx_d     = idx_q;
    best_d    = best_q;
    min_idx_d = min_idx_q;
    kvo_d     = kvo_q;
    wr_en     = 1'b0;
    wr_idx    = '0;
    wr_data   = '0;
    unique case (state_q)
      IDLE: begin
        if (enq && (!deq || empty)) begin
          // Plain enqueue (also enq+deq on an empty queue): append.
          if (!full) begin
            wr_en   = 1'b1;
            wr_idx  = count_q[IW-1:0];
            wr_data = kvi;
            count_d = count_q + CW'(1);
            idx_d   = '0;
            state_d = SCAN;
          end
        end else if (deq && !empty) begin
          // Dequeue moves the last entry into the hole left by the minimum;
          // enq+deq overwrites the minimum in place (replace).
          wr_en   = 1'b1;
          wr_idx  = min_idx_q;
          wr_data = enq ? kvi : arr_q[IW'(count_q - CW'(1))];
          count_d = enq ? count_q : count_q - CW'(1);
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (count_q == '0) begin
          kvo_d     = '0;
          min_idx_d = '0;
          state_d   = IDLE;
        end else begin
          best_d = sel;
          idx_d  = idx_q + CW'(1);
          if (idx_q == count_q - CW'(1)) begin
            kvo_d     = arr_q[sel];
            min_idx_d = sel;
            state_d   = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      count_q   <= '0;
      idx_q     <= '0;
      best_q    <= '0;
      min_idx_q <= '0;
      kvo_q     <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      idx_q     <= idx_d;
      best_q    <= best_d;
      min_idx_q <= min_idx_d;
      kvo_q     <= kvo_d;
    end
  end

  // Storage has no reset; entries beyond count are never read.
  always_ff @(posedge clk) begin
    if (wr_en) arr_q[wr_idx] <= wr_data;
  end

`ifdef PQ_ERR_EN
  logic err_q, drop;

  assign drop = (state_q == SCAN) ? (enq || deq)
              : ((enq && !deq && full) || (deq && !enq && empty));
  assign err  = err_q;

  always_ff @(posedge clk) begin
    if (rst)       err_q <= 1'b0;
    else if (drop) err_q <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_scan_pq.sv
module tb_scan_pq;

  logic        clk = 1'b0;
  logic        rst, enq, deq;
  logic [15:0] kvi, kvo;
  logic        full, empty, busy;
`ifdef PQ_ERR_EN
  logic        err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scan_pq #(.DEPTH(4), .KW(8), .VW(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .enq  (enq),
    .deq  (deq),
    .kvi  (kvi),
    .kvo  (kvo),
    .full (full),
    .empty(empty),
    .busy (busy)
`ifdef PQ_ERR_EN
    ,
    .err  (err)
`endif
  );

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; enq = 1'b0; deq = 1'b0;
    @(negedge clk); rst = 1'b0;
  endtask

  // One-cycle request pulse, then count busy cycles (bounded at 64).
  task automatic op(input logic e, input logic d, input logic [15:0] kv,
                    output int bc);
    @(negedge clk); enq = e; deq = d; kvi = kv;
    @(negedge clk); enq = 1'b0; deq = 1'b0;
    bc = 0;
    while (busy && bc < 64) begin
      bc++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({empty, full, busy, kvo} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
        errors++;
        $display("FAIL reset_idle cyc%0d: e/f/b/kvo=%b%b%b %h want 100 0000",
                 i, empty, full, busy, kvo);
      end
`ifdef PQ_ERR_EN
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", err); end
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_enq_seq();
    logic [15:0] kv  [3] = '{16'h3011, 16'h1022, 16'h2033};
    logic [15:0] exp [3] = '{16'h3011, 16'h1022, 16'h1022};
    int bc;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      op(1'b1, 1'b0, kv[i], bc);
      checks++;
      if (kvo !== exp[i] || bc != i + 1) begin
        errors++;
        $display("FAIL enq_seq%0d: kvo=%h busy=%0d want %h busy=%0d", i, kvo, bc, exp[i], i + 1);
      end
    end
  endtask

  task automatic test_fill_drain();
    logic [15:0] kv  [4] = '{16'h4044, 16'h1011, 16'h3033, 16'h2022};
    logic [15:0] exp [4] = '{16'h2022, 16'h3033, 16'h4044, 16'h0000};
    int          ebc [4] = '{3, 2, 1, 1};
    int bc;
    do_reset();
    for (int i = 0; i < 4; i++) op(1'b1, 1'b0, kv[i], bc);
    checks++;
    if (full !== 1'b1 || kvo !== 16'h1011) begin
      errors++; $display("FAIL fill: full=%b kvo=%h want 1 1011", full, kvo);
    end
    op(1'b1, 1'b0, 16'h0555, bc);
    checks++;
    if (bc != 0 || kvo !== 16'h1011 || full !== 1'b1) begin
      errors++; $display("FAIL enq_full: busy=%0d kvo=%h full=%b want 0 1011 1", bc, kvo, full);
    end
`ifdef PQ_ERR_EN
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_enq_full got %b want 1", err); end
`endif
    for (int i = 0; i < 4; i++) begin
      op(1'b0, 1'b1, 16'h0, bc);
      checks++;
      if (kvo !== exp[i] || bc != ebc[i] || empty !== (i == 3)) begin
        errors++;
        $display("FAIL drain%0d: kvo=%h busy=%0d empty=%b want %h %0d %b",
                 i, kvo, bc, empty, exp[i], ebc[i], (i == 3));
      end
    end
  endtask

  task automatic test_replace();
    logic [15:0] kv [4] = '{16'h1011, 16'h2022, 16'h3033, 16'h4044};
    int bc;
    do_reset();
    for (int i = 0; i < 4; i++) op(1'b1, 1'b0, kv[i], bc);
    op(1'b1, 1'b1, 16'h2500, bc);
    checks++;
    if (kvo !== 16'h2022 || full !== 1'b1 || bc != 4) begin
      errors++; $display("FAIL replace: kvo=%h full=%b busy=%0d want 2022 1 4", kvo, full, bc);
    end
  endtask

  task automatic test_ties();
    int bc;
    do_reset();
    op(1'b1, 1'b0, 16'h5001, bc);
    op(1'b1, 1'b0, 16'h5002, bc);
    checks++;
    if (kvo !== 16'h5001) begin errors++; $display("FAIL tie: kvo=%h want 5001", kvo); end
    op(1'b0, 1'b1, 16'h0, bc);
    checks++;
    if (kvo !== 16'h5002 || bc != 1) begin
      errors++; $display("FAIL tie_deq: kvo=%h busy=%0d want 5002 1", kvo, bc);
    end
  endtask

  task automatic test_disrupt();
    int bc;
    do_reset();
    op(1'b0, 1'b1, 16'h0, bc);
    checks++;
    if (bc != 0 || kvo !== 16'h0000 || empty !== 1'b1) begin
      errors++; $display("FAIL deq_empty: busy=%0d kvo=%h empty=%b want 0 0000 1", bc, kvo, empty);
    end
`ifdef PQ_ERR_EN
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_deq_empty got %b want 1", err); end
`endif
    // Request during a scan must be dropped.
    do_reset();
    op(1'b1, 1'b0, 16'h3011, bc);
    op(1'b1, 1'b0, 16'h1022, bc);
    @(negedge clk); enq = 1'b1; kvi = 16'h2033;
    @(negedge clk); kvi = 16'h0111;          // still high while busy
    @(negedge clk); enq = 1'b0;
    bc = 0;
    while (busy && bc < 64) begin bc++; @(negedge clk); end
    checks++;
    if (kvo !== 16'h1022 || full !== 1'b0 || bc > 2) begin
      errors++; $display("FAIL busy_drop: kvo=%h full=%b want 1022 0", kvo, full);
    end
`ifdef PQ_ERR_EN
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_busy got %b want 1", err); end
`endif
    // Reset in the middle of a scan.
    @(negedge clk); enq = 1'b1; kvi = 16'h0a0a;
    @(negedge clk); enq = 1'b0;
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL scan_start: busy=%b want 1", busy); end
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    checks++;
    if ({busy, empty, full, kvo} !== {1'b0, 1'b1, 1'b0, 16'h0000}) begin
      errors++; $display("FAIL rst_mid_scan: b/e/f/kvo=%b%b%b %h want 010 0000", busy, empty, full, kvo);
    end
`ifdef PQ_ERR_EN
    checks++;
    if (err !== 1'b0) begin errors++; $display("FAIL err_clear got %b want 0", err); end
`endif
  endtask

  initial begin
    rst = 1'b1; enq = 1'b0; deq = 1'b0; kvi = '0;
    test_reset();
    test_enq_seq();
    test_fill_drain();
    test_replace();
    test_ties();
    test_disrupt();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
